entrada_digito: RTL
===================

// Module: entrada_digito
// PURPOSE
//  Operator front end for the code-lock controller. Synchronises the raw 4-bit
//  digit switches and the "insert" push-button, and debounces the button.
//  Each debounced press produces exactly one single-cycle insere pulse, with the
//  switch value frozen on numero. insere/numero connect directly to the
//  controller's insere/numero inputs.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  consecutive stable cycles required per edge (10 ms @ 50 MHz); >=2
//  SYNC_STAGES      2       flops in each synchroniser chain; >=2
// PORTS
//  clk            in   1  system clock, rising edge
//  reset_n        in   1  asynchronous, active-low reset
//  botao          in   1  raw push-button, active high, asynchronous, bouncy
//  chaves         in   4  raw digit switches, asynchronous
//  insere         out  1  one-cycle pulse per accepted press
//  numero         out  4  digit captured at the press; held until the next press
//  digito_valido  out  1  registered (numero <= 9); updates in the same cycle as numero
//  ocupado        out  1  high in every state except OCIOSO
// BEHAVIOUR
//  Interface: one clock (clk); reset_n is asynchronous, active-low.
//  Reset: all outputs are 0; FSM = OCIOSO; counter = 0; synchroniser flops = 0.
//   Release is used synchronously through the flops; no output changes at release.
//  botao_s / chaves_s are the SYNC_STAGES-deep synchronised copies. Only these feed logic.
//  Counter: $clog2(DEBOUNCE_CYCLES)-bit; cleared on every state change; saturates, never wraps.
//  FSM:
//   OCIOSO         botao_s=1 -> FILTRA_PRESS (cnt=0).
//   FILTRA_PRESS   botao_s=0 -> OCIOSO; else cnt++.
//                  When cnt reaches DEBOUNCE_CYCLES-1 with botao_s=1 -> PRESSIONADO,
//                  and on the same edge: numero<=chaves_s, digito_valido<=(chaves_s<=9), insere<=1.
//   PRESSIONADO    insere is forced 0 from this point. botao_s=0 -> FILTRA_SOLTA (cnt=0).
//   FILTRA_SOLTA   botao_s=1 -> PRESSIONADO (a bounce while releasing; no new pulse);
//                  else cnt++. When cnt reaches DEBOUNCE_CYCLES-1 -> OCIOSO.
//  insere is registered, exactly 1 cycle wide, and never high on two consecutive cycles.
//   numero is already valid in the cycle insere=1.
//  Latency: a clean botao rise gives insere high SYNC_STAGES+DEBOUNCE_CYCLES cycles
//   after the first clk edge that samples botao=1 (tolerance +-1 cycle).
//  Minimum press-to-press spacing is 2*DEBOUNCE_CYCLES cycles.
//  A chaves change while ocupado=1 does not alter numero. numero changes only with insere.
//  An out-of-range digit (10..15) still pulses insere. digito_valido=0 marks it;
//   the downstream controller ignores such digits.
//  Reset asserted mid-filter or mid-press: immediate return to reset values, no pulse.
//   After release, a button still held is treated as a fresh press (full debounce, then a pulse).
//  A glitch shorter than DEBOUNCE_CYCLES cycles in FILTRA_PRESS produces no pulse.
// STRUCTURE
//  Package entrada_pkg: state localparams OCIOSO=2'd0, FILTRA_PRESS=2'd1,
//   PRESSIONADO=2'd2, FILTRA_SOLTA=2'd3; DIGITO_MAX=4'd9.
//  Sub-module sincronizador #(WIDTH, STAGES): instantiated for botao (WIDTH=1) and chaves (WIDTH=4).
//  Top: counter, FSM, and the output registers (insere, numero, digito_valido).
// TESTING  (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
//  1 reset_n=0 -> 1; idle 20 cycles -> insere=0, numero=0, ocupado=0 throughout.
//  2 chaves=5; botao high for 20 cycles -> exactly one insere pulse, numero=5, digito_valido=1,
//    pulse ~6 cycles after the rise.
//  3 botao toggled 1,0,1,0 at 1-2 cycle intervals, then held low -> no insere; FSM back in OCIOSO.
//  4 Press with chaves=8; during hold, chaves=3; release -> numero stays 8.
//    Next press -> numero=3, one new pulse.
//  5 Release bounce: while held, a 2-cycle low glitch, then a 2-cycle high -> no second pulse.
//    Then a clean release -> ocupado drops after the filter.
//  6 chaves=12, press -> insere pulse, numero=12, digito_valido=0.
//    reset_n=0 mid-FILTRA_PRESS on the next press -> no pulse, all outputs 0.

Source files
------------

// File: rtl/entrada_digito_pkg.sv
`default_nettype none
// ============================================================================
// entrada_pkg : shared state encoding and digit limits for entrada_digito.
// Revision 1.0
// ============================================================================
package entrada_pkg;

  localparam logic [1:0] OCIOSO       = 2'd0;
  localparam logic [1:0] FILTRA_PRESS = 2'd1;
  localparam logic [1:0] PRESSIONADO  = 2'd2;
  localparam logic [1:0] FILTRA_SOLTA = 2'd3;

  localparam logic [3:0] DIGITO_MAX = 4'd9;

  function automatic logic digito_ok(input logic [3:0] d);
    return (d <= DIGITO_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/entrada_digito_if.sv
`default_nettype none
// ============================================================================
// entrada_digito_if : operator switches/button in, digit strobe out.
// Revision 1.0
// ============================================================================
interface entrada_digito_if;

  logic       botao;
  logic [3:0] chaves;
  logic       insere;
  logic [3:0] numero;
  logic       digito_valido;
  logic       ocupado;

  // master = operator panel side, slave = entrada_digito
  modport master (
    output botao, chaves,
    input  insere, numero, digito_valido, ocupado
  );

  modport slave (
    input  botao, chaves,
    output insere, numero, digito_valido, ocupado
  );

endinterface
`default_nettype wire

// File: rtl/entrada_digito_sincronizador.sv
`default_nettype none
// ============================================================================
// sincronizador : STAGES-deep flop chain bringing an asynchronous bus into clk.
// Revision 1.0
// ============================================================================
module sincronizador #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic [WIDTH-1:0] d,
  output      logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] r_chain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/entrada_digito.sv
`default_nettype none
// ============================================================================
// entrada_digito : synchronises and debounces the insert button, emitting one
// insere pulse per press with the switch digit frozen on numero.
// Revision 1.0
// ============================================================================
module entrada_digito
  import entrada_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input wire logic         clk,
  input wire logic         reset_n,
  entrada_digito_if.slave  ent
);

  localparam int unsigned c_cnt_w   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic               w_botao_s;
  logic [3:0]         w_chaves_s;
  logic [1:0]         r_estado;
  logic [1:0]         w_proximo;
  logic [c_cnt_w-1:0] r_cnt;
  logic               w_filtrando;
  logic               w_captura;
  logic               w_ocupado;
  logic               r_insere;
  logic [3:0]         r_numero;
  logic               r_valido;

  sincronizador #(
    .WIDTH  (1),
    .STAGES (SYNC_STAGES)
  ) u_sync_botao (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (ent.botao),
    .q       (w_botao_s)
  );

  sincronizador #(
    .WIDTH  (4),
    .STAGES (SYNC_STAGES)
  ) u_sync_chaves (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (ent.chaves),
    .q       (w_chaves_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_proximo;
    end
  end

  always_comb begin
    w_proximo = r_estado;
    case (r_estado)
      OCIOSO: begin
        if (w_botao_s) w_proximo = FILTRA_PRESS;
      end
      FILTRA_PRESS: begin
        if (!w_botao_s)              w_proximo = OCIOSO;
        else if (r_cnt == c_cnt_max) w_proximo = PRESSIONADO;
      end
      PRESSIONADO: begin
        if (!w_botao_s) w_proximo = FILTRA_SOLTA;
      end
      FILTRA_SOLTA: begin
        // a high sample while releasing is a bounce, not a new press
        if (w_botao_s)               w_proximo = PRESSIONADO;
        else if (r_cnt == c_cnt_max) w_proximo = OCIOSO;
      end
      default: w_proximo = OCIOSO;
    endcase
  end

  always_comb begin
    w_ocupado   = (r_estado != OCIOSO);
    w_filtrando = (r_estado == FILTRA_PRESS) || (r_estado == FILTRA_SOLTA);
    w_captura   = (r_estado == FILTRA_PRESS) && w_botao_s && (r_cnt == c_cnt_max);
  end

  // restarts on every state change; holds at its maximum rather than wrapping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_proximo != r_estado) begin
      r_cnt <= '0;
    end else if (w_filtrando && (r_cnt != c_cnt_max)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_insere <= 1'b0;
      r_numero <= 4'd0;
      r_valido <= 1'b0;
    end else begin
      r_insere <= w_captura;
      if (w_captura) begin
        r_numero <= w_chaves_s;
        r_valido <= digito_ok(w_chaves_s);
      end
    end
  end

  assign ent.insere        = r_insere;
  assign ent.numero        = r_numero;
  assign ent.digito_valido = r_valido;
  assign ent.ocupado       = w_ocupado;

endmodule
`default_nettype wire
